fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_unit_jal_predecode.sv | 13 +
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants, state encoding and J-immediate helper for the instruction fetch unit.
package fetch_unit_pkg;

  localparam logic [31:0] ResetPcDefault = 32'h0000_0000;
  localparam logic [6:0]  OpcJal         = 7'b1101111;
  localparam logic [31:0] InstrNop       = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StKill} fetch_state_e;

  function automatic logic [31:0] jal_imm(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_jal_predecode.sv
// Pre-decode of jal: opcode match and sign-extended J-type offset.
module jal_predecode
  import fetch_unit_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_jal,
  output logic [31:0] imm
);

  assign is_jal = (instr[6:0] == OpcJal);
  assign imm    = jal_imm(instr);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch with one-entry skid buffer, redirect/kill handling and IF/ID register.
// Define FETCH_JAL_PREDICT_EN to follow jal targets at fetch time without a bubble.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_ren,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_stall,
  input  logic        stall_id,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
);

  fetch_state_e state_q;
  logic         ren_q;
  logic [31:0]  pc_q;
  logic [31:0]  target_q;
  logic [31:0]  buf_instr_q;
  logic [31:0]  buf_pc_q;
  logic         id_valid_q;
  logic [31:0]  id_instr_q;
  logic [31:0]  id_pc_q;
  logic [31:0]  id_pc4_q;

  logic [31:0]  redir_aligned;
  logic [31:0]  acc_instr;
  logic [31:0]  acc_pc;
  logic [31:0]  acc_pc4;
  logic [31:0]  next_pc;

  assign redir_aligned = {redirect_pc[31:2], 2'b00};

  // The instruction being accepted comes from memory in FETCH, from the skid buffer in HOLD.
  always_comb begin
    acc_instr = imem_rdata;
    acc_pc    = pc_q;
    if (state_q == StHold) begin
      acc_instr = buf_instr_q;
      acc_pc    = buf_pc_q;
    end
  end

  assign acc_pc4 = acc_pc + 32'd4;

`ifdef FETCH_JAL_PREDICT_EN
  logic        is_jal;
  logic [31:0] jal_off;

  jal_predecode u_jal_predecode (
    .instr  (acc_instr),
    .is_jal (is_jal),
    .imm    (jal_off)
  );

  assign next_pc = is_jal ? (acc_pc + jal_off) : acc_pc4;
`else
  assign next_pc = acc_pc4;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ren_q       <= 1'b0;
      pc_q        <= RESET_PC;
      target_q    <= 32'h0;
      buf_instr_q <= 32'h0;
      buf_pc_q    <= 32'h0;
      id_valid_q  <= 1'b0;
      id_instr_q  <= InstrNop;
      id_pc_q     <= 32'h0;
      id_pc4_q    <= 32'h0;
    end else begin
      // Redirect flushes IF/ID regardless of decode back-pressure.
      if (redirect) begin
        id_valid_q <= 1'b0;
        id_instr_q <= InstrNop;
      end
      unique case (state_q)
        StIdle: begin
          if (redirect) pc_q <= redir_aligned;
          state_q <= StFetch;
          ren_q   <= 1'b1;
        end
        StFetch: begin
          if (redirect) begin
            if (imem_stall) begin
              target_q <= redir_aligned;
              state_q  <= StKill;
            end else begin
              pc_q <= redir_aligned;
            end
          end else if (!imem_stall) begin
            if (!stall_id) begin
              id_valid_q <= 1'b1;
              id_instr_q <= acc_instr;
              id_pc_q    <= acc_pc;
              id_pc4_q   <= acc_pc4;
              pc_q       <= next_pc;
            end else begin
              buf_instr_q <= imem_rdata;
              buf_pc_q    <= pc_q;
              state_q     <= StHold;
              ren_q       <= 1'b0;
            end
          end else if (!stall_id) begin
            id_valid_q <= 1'b0;
          end
        end
        StHold: begin
          if (redirect) begin
            pc_q    <= redir_aligned;
            state_q <= StFetch;
            ren_q   <= 1'b1;
          end else if (!stall_id) begin
            id_valid_q <= 1'b1;
            id_instr_q <= acc_instr;
            id_pc_q    <= acc_pc;
            id_pc4_q   <= acc_pc4;
            pc_q       <= next_pc;
            state_q    <= StFetch;
            ren_q      <= 1'b1;
          end
        end
        StKill: begin
          if (redirect) target_q <= redir_aligned;
          // The stale word returned now is dropped; resume at the newest target.
          if (!imem_stall) begin
            pc_q    <= redirect ? redir_aligned : target_q;
            state_q <= StFetch;
          end
        end
        default: begin
          state_q <= StIdle;
          ren_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_ren  = ren_q;
  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign id_pc4    = id_pc4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, memory/decode stalls, redirects, kill, jal, wrap, reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_stall;
  logic        stall_id;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        jal_at_20;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef FETCH_JAL_PREDICT_EN
  localparam logic [31:0] JalNext = 32'h0000_0028;
`else
  localparam logic [31:0] JalNext = 32'h0000_0024;
`endif

  always #5 clk = ~clk;

  // Memory returns address-tagged words; optionally a jal x0,+8 at 0x20.
  assign imem_rdata = (jal_at_20 && imem_addr == 32'h20) ? 32'h0080_006F
                                                         : (32'hA000_0000 | imem_addr);

  fetch_unit #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_ren    (imem_ren),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_stall  (imem_stall),
    .stall_id    (stall_id),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc4      (id_pc4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_stall = 1'b0; stall_id = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; jal_at_20 = 1'b0;
    step(); step();
    check("rst_ren", {31'b0, imem_ren}, 32'd0);
    check("rst_valid", {31'b0, id_valid}, 32'd0);
    check("rst_instr", id_instr, 32'h13);
    check("rst_pc", id_pc, 32'h0);
    check("rst_pc4", id_pc4, 32'h0);
    rst = 1'b0;

    // Streaming from reset
    step();
    check("idle_ren", {31'b0, imem_ren}, 32'd1);
    check("idle_addr", imem_addr, 32'h0);
    check("idle_valid", {31'b0, id_valid}, 32'd0);
    step();
    check("s0_valid", {31'b0, id_valid}, 32'd1);
    check("s0_pc", id_pc, 32'h0);
    check("s0_instr", id_instr, 32'hA000_0000);
    check("s0_pc4", id_pc4, 32'h4);
    step();
    check("s1_pc", id_pc, 32'h4);
    check("s1_addr", imem_addr, 32'h8);

    // Memory stall at 8 for three cycles
    imem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mst_addr", imem_addr, 32'h8);
      check("mst_valid", {31'b0, id_valid}, 32'd0);
    end
    imem_stall = 1'b0;
    step();
    check("mst_pc", id_pc, 32'h8);
    check("mst_instr", id_instr, 32'hA000_0008);
    check("mst_valid1", {31'b0, id_valid}, 32'd1);
    step();
    check("mst_next", id_pc, 32'hC);
    check("mst_addr2", imem_addr, 32'h10);

    // Decode stall: word at 0x10 goes to the skid buffer
    stall_id = 1'b1;
    step();
    check("hold_ren", {31'b0, imem_ren}, 32'd0);
    check("hold_pc", id_pc, 32'hC);
    check("hold_instr", id_instr, 32'hA000_000C);
    step();
    check("hold_pc2", id_pc, 32'hC);
    stall_id = 1'b0;
    step();
    check("hold_out_pc", id_pc, 32'h10);
    check("hold_out_instr", id_instr, 32'hA000_0010);
    check("hold_out_ren", {31'b0, imem_ren}, 32'd1);
    check("hold_out_addr", imem_addr, 32'h14);
    step();
    check("hold_next", id_pc, 32'h14);

    // Redirect during memory stall -> kill
    imem_stall = 1'b1;
    step();
    check("k_addr0", imem_addr, 32'h18);
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    check("k_addr1", imem_addr, 32'h18);
    check("k_ren", {31'b0, imem_ren}, 32'd1);
    check("k_valid", {31'b0, id_valid}, 32'd0);
    check("k_instr", id_instr, 32'h13);
    redirect = 1'b0;
    step();
    check("k_addr2", imem_addr, 32'h18);
    imem_stall = 1'b0;
    step();
    check("k_addr3", imem_addr, 32'h100);
    check("k_drop_valid", {31'b0, id_valid}, 32'd0);
    check("k_drop_instr", id_instr, 32'h13);
    step();
    check("k_first_pc", id_pc, 32'h100);
    check("k_first_instr", id_instr, 32'hA000_0100);

    // Redirect with simultaneous decode stall and unaligned target
    redirect = 1'b1; redirect_pc = 32'h102; stall_id = 1'b1;
    step();
    check("rs_addr", imem_addr, 32'h100);
    check("rs_valid", {31'b0, id_valid}, 32'd0);
    check("rs_instr", id_instr, 32'h13);
    redirect = 1'b0; stall_id = 1'b0;
    step();
    check("rs_pc", id_pc, 32'h100);

    // jal at 0x20
    jal_at_20 = 1'b1; redirect = 1'b1; redirect_pc = 32'h20;
    step();
    redirect = 1'b0;
    check("jal_addr", imem_addr, 32'h20);
    step();
    check("jal_instr", id_instr, 32'h0080_006F);
    check("jal_pc", id_pc, 32'h20);
    check("jal_next", imem_addr, JalNext);
    jal_at_20 = 1'b0;

    // PC wrap-around
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    step();
    check("wrap_pc", id_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", id_pc4, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);

    // Reset out of HOLD
    stall_id = 1'b1;
    step();
    check("rh_ren", {31'b0, imem_ren}, 32'd0);
    rst = 1'b1;
    step();
    check("rh_valid", {31'b0, id_valid}, 32'd0);
    check("rh_pc", id_pc, 32'h0);
    check("rh_instr", id_instr, 32'h13);
    check("rh_ren2", {31'b0, imem_ren}, 32'd0);
    rst = 1'b0; stall_id = 1'b0;
    step();
    check("rh_addr", imem_addr, 32'h0);
    check("rh_ren3", {31'b0, imem_ren}, 32'd1);

    // Redirect while in KILL overwrites the target
    imem_stall = 1'b1;
    step();
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_pc = 32'h303;
    step();
    check("kk_addr", imem_addr, 32'h0);
    redirect = 1'b0; imem_stall = 1'b0;
    step();
    check("kk_target", imem_addr, 32'h300);
    check("kk_valid", {31'b0, id_valid}, 32'd0);
    step();
    check("kk_pc", id_pc, 32'h300);
    check("kk_instr", id_instr, 32'hA000_0300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
